// File: rtl/hilo_sequencer.sv
// HI/LO sequencer: launches a multi-cycle mult/div unit, waits out its latency and
// copies the result into HI/LO. Optional mthi/mtlo write port under HILO_MTHILO_EN.
module hilo_sequencer #(
    parameter int unsigned DIV_LAT  = 33,
    parameter int unsigned MULT_LAT = 33
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic        op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic [31:0] op_a,
    output logic [31:0] op_b,
    output logic        unit_go,
    input  logic [31:0] div_hi,
    input  logic [31:0] div_lo,
    input  logic [31:0] mult_hi,
    input  logic [31:0] mult_lo,
`ifdef HILO_MTHILO_EN
    input  logic        mt_en,
    input  logic        mt_sel,
    input  logic [31:0] mt_data,
`endif
    output logic [31:0] hi_out,
    output logic [31:0] lo_out,
    output logic        busy,
    output logic        done,
    output logic        div0
);

    localparam int unsigned DATA_W = 32;
    localparam int unsigned CNT_W  = 6;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        FIN  = 2'b10
    } state_t;

    state_t              state, state_nxt;
    logic [CNT_W-1:0]    cnt, cnt_nxt;
    logic                op_q, op_q_nxt;
    logic                flag, flag_nxt;
    logic [DATA_W-1:0]   op_a_nxt, op_b_nxt, hi_nxt, lo_nxt;
    logic                go_nxt, busy_nxt, done_nxt, div0_nxt;

    // State register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        op_q_nxt  = op_q;
        flag_nxt  = flag;
        op_a_nxt  = op_a;
        op_b_nxt  = op_b;
        hi_nxt    = hi_out;
        lo_nxt    = lo_out;
        go_nxt    = 1'b0;
        busy_nxt  = 1'b0;
        done_nxt  = 1'b0;
        div0_nxt  = 1'b0;

        case (state)
            IDLE: begin
                if (start) begin
                    if (op || (B != '0)) begin
                        op_q_nxt  = op;
                        op_a_nxt  = A;
                        op_b_nxt  = B;
                        cnt_nxt   = op ? CNT_W'(MULT_LAT) : CNT_W'(DIV_LAT);
                        go_nxt    = 1'b1;
                        busy_nxt  = 1'b1;
                        state_nxt = RUN;
                    end else begin
                        // Divide by zero never reaches the divider
                        flag_nxt  = 1'b1;
                        done_nxt  = 1'b1;
                        div0_nxt  = 1'b1;
                        state_nxt = FIN;
                    end
                end
`ifdef HILO_MTHILO_EN
                else if (mt_en) begin
                    if (mt_sel) begin
                        hi_nxt = mt_data;
                    end else begin
                        lo_nxt = mt_data;
                    end
                end
`endif
            end
            RUN: begin
                cnt_nxt = cnt - CNT_W'(1);
                if (cnt <= CNT_W'(1)) begin
                    hi_nxt    = op_q ? mult_hi : div_hi;
                    lo_nxt    = op_q ? mult_lo : div_lo;
                    done_nxt  = 1'b1;
                    div0_nxt  = flag;
                    state_nxt = FIN;
                end else begin
                    busy_nxt = 1'b1;
                end
            end
            FIN: begin
                flag_nxt  = 1'b0;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Datapath and registered outputs
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt     <= '0;
            op_q    <= 1'b0;
            flag    <= 1'b0;
            op_a    <= '0;
            op_b    <= '0;
            hi_out  <= '0;
            lo_out  <= '0;
            unit_go <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            div0    <= 1'b0;
        end else begin
            cnt     <= cnt_nxt;
            op_q    <= op_q_nxt;
            flag    <= flag_nxt;
            op_a    <= op_a_nxt;
            op_b    <= op_b_nxt;
            hi_out  <= hi_nxt;
            lo_out  <= lo_nxt;
            unit_go <= go_nxt;
            busy    <= busy_nxt;
            done    <= done_nxt;
            div0    <= div0_nxt;
        end
    end

endmodule

// File: tb/tb_hilo_sequencer.sv
// Bench for hilo_sequencer: timeline model of each accepted operation plus directed
// scenarios with literal expectations. mthi/mtlo scenario only under HILO_MTHILO_EN.
module tb_hilo_sequencer;

    localparam int unsigned DLAT = 33;
    localparam int unsigned MLAT = 5;

    logic        clock = 1'b0;
    logic        reset;
    logic        start = 1'b0;
    logic        op = 1'b0;
    logic [31:0] A = '0, B = '0;
    logic [31:0] div_hi = '0, div_lo = '0, mult_hi = '0, mult_lo = '0;
`ifdef HILO_MTHILO_EN
    logic        mt_en = 1'b0, mt_sel = 1'b0;
    logic [31:0] mt_data = '0;
`endif
    logic [31:0] op_a, op_b, hi_out, lo_out;
    logic        unit_go, busy, done, div0;

    hilo_sequencer #(.DIV_LAT(DLAT), .MULT_LAT(MLAT)) dut (
        .clock(clock), .reset(reset), .start(start), .op(op), .A(A), .B(B),
        .op_a(op_a), .op_b(op_b), .unit_go(unit_go),
        .div_hi(div_hi), .div_lo(div_lo), .mult_hi(mult_hi), .mult_lo(mult_lo),
`ifdef HILO_MTHILO_EN
        .mt_en(mt_en), .mt_sel(mt_sel), .mt_data(mt_data),
`endif
        .hi_out(hi_out), .lo_out(lo_out), .busy(busy), .done(done), .div0(div0)
    );

    always #5 clock = ~clock;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Timeline model: each accepted operation fixes the cycles of its go/busy/done
    int          cyc = 0;
    int          go_cyc = -1, run_end = -1, done_cyc = -1, idle_from = 0;
    bit          m_op = 1'b0, m_div0 = 1'b0;
    logic [31:0] e_hi = '0, e_lo = '0, e_a = '0, e_b = '0;

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            go_cyc = -1; run_end = -1; done_cyc = -1; idle_from = 0;
            m_div0 = 1'b0;
            e_hi = '0; e_lo = '0; e_a = '0; e_b = '0;
        end else begin
            if (cyc == run_end) begin
                e_hi = m_op ? mult_hi : div_hi;
                e_lo = m_op ? mult_lo : div_lo;
            end
            if (cyc >= idle_from && start) begin
                if (op || B != 0) begin
                    m_op = op; e_a = A; e_b = B; m_div0 = 1'b0;
                    go_cyc    = cyc + 1;
                    run_end   = cyc + (op ? int'(MLAT) : int'(DLAT));
                    done_cyc  = run_end + 1;
                    idle_from = run_end + 2;
                end else begin
                    m_div0 = 1'b1;
                    go_cyc = -1; run_end = -1;
                    done_cyc  = cyc + 1;
                    idle_from = cyc + 2;
                end
            end
`ifdef HILO_MTHILO_EN
            else if (cyc >= idle_from && mt_en) begin
                if (mt_sel) e_hi = mt_data;
                else        e_lo = mt_data;
            end
`endif
            cyc++;
        end
    end

    // Per-cycle compare of every output against the model
    always @(negedge clock) begin
        logic e_busy, e_done;
        e_busy = (go_cyc >= 0) && (cyc >= go_cyc) && (cyc <= run_end);
        e_done = (cyc == done_cyc);
        chk("unit_go", 32'(unit_go), 32'(cyc == go_cyc));
        chk("busy",    32'(busy),    32'(e_busy));
        chk("done",    32'(done),    32'(e_done));
        chk("div0",    32'(div0),    32'(e_done && m_div0));
        chk("hi_out",  hi_out, e_hi);
        chk("lo_out",  lo_out, e_lo);
        chk("op_a",    op_a,   e_a);
        chk("op_b",    op_b,   e_b);
    end

    int n_go = 0, n_busy = 0, n_done = 0;
    always @(posedge clock) begin
        if (reset) begin
            if (unit_go) n_go++;
            if (busy)    n_busy++;
            if (done)    n_done++;
        end
    end

    // Start pulse sampled on the next rising edge; called right after a falling edge
    task automatic issue(input logic o, input logic [31:0] a, input logic [31:0] b);
        op = o; A = a; B = b; start = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
    endtask

    // Falling edges until done is seen (first one is the cycle after acceptance)
    task automatic wait_done(input string nm, output int n);
        n = 0;
        for (int i = 1; i <= 100; i++) begin
            @(negedge clock);
            if (done) begin
                n = i;
                break;
            end
        end
        if (n == 0) chk({nm, "_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic zero_clr();
        n_go = 0; n_busy = 0; n_done = 0;
    endtask

    task automatic all_zero(input string nm);
        chk({nm, "_hi"}, hi_out, 32'd0);
        chk({nm, "_lo"}, lo_out, 32'd0);
        chk({nm, "_opa"}, op_a, 32'd0);
        chk({nm, "_opb"}, op_b, 32'd0);
        chk({nm, "_ctl"}, {28'd0, busy, done, div0, unit_go}, 32'd0);
    endtask

    initial begin
        int n;
        reset = 1'b0;
        repeat (2) @(negedge clock);
        all_zero("reset");
        reset = 1'b1;
        @(negedge clock);

        // div 100/7: 33 busy cycles, done on the 34th cycle
        div_hi = 32'd2; div_lo = 32'd14; mult_hi = 32'h1111_1111; mult_lo = 32'h2222_2222;
        zero_clr();
        issue(1'b0, 32'd100, 32'd7);
        wait_done("div", n);
        chk("div_lat", 32'(n), 32'd34);
        chk("div_hi", hi_out, 32'd2);
        chk("div_lo", lo_out, 32'd14);
        chk("div_div0", 32'(div0), 32'd0);
        @(negedge clock);
        chk("div_gos", 32'(n_go), 32'd1);
        chk("div_busy", 32'(n_busy), 32'd33);

        // divide by zero: done+div0 next cycle, HI/LO untouched, no unit_go
        zero_clr();
        issue(1'b0, 32'd5, 32'd0);
        wait_done("dz", n);
        chk("dz_lat", 32'(n), 32'd1);
        chk("dz_div0", 32'(div0), 32'd1);
        chk("dz_hi", hi_out, 32'd2);
        chk("dz_lo", lo_out, 32'd14);
        @(negedge clock);
        chk("dz_gos", 32'(n_go), 32'd0);

        // mult 0xFFFFFFFF*2 selects the multiplier result after MULT_LAT+1
        div_hi = 32'hBAD0_0001; div_lo = 32'hBAD0_0002;
        mult_hi = 32'd1; mult_lo = 32'hFFFF_FFFE;
        issue(1'b1, 32'hFFFF_FFFF, 32'd2);
        wait_done("mul", n);
        chk("mul_lat", 32'(n), 32'(MLAT + 1));
        chk("mul_hi", hi_out, 32'd1);
        chk("mul_lo", lo_out, 32'hFFFF_FFFE);
        chk("mul_opa", op_a, 32'hFFFF_FFFF);
        @(negedge clock);

        // start during RUN and during FIN ignored; held start accepted in next IDLE
        zero_clr();
        mult_hi = 32'h0000_00AB; mult_lo = 32'h0000_00CD;
        div_hi = 32'd1; div_lo = 32'd2;
        issue(1'b1, 32'd6, 32'd7);
        repeat (2) @(negedge clock);
        op = 1'b0; A = 32'd99; B = 32'd9; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        wait_done("ign", n);
        chk("ign_lat", 32'(n), 32'(MLAT + 1 - 3));
        chk("ign_hi", hi_out, 32'h0000_00AB);
        op = 1'b0; A = 32'd7; B = 32'd3; start = 1'b1;
        @(negedge clock);
        chk("ign_fin_opa", op_a, 32'd6);
        @(posedge clock);
        #1 start = 1'b0;
        wait_done("acc", n);
        chk("acc_lat", 32'(n), 32'(DLAT + 1));
        chk("acc_opa", op_a, 32'd7);
        chk("acc_lo", lo_out, 32'd2);
        @(negedge clock);
        chk("ign_gos", 32'(n_go), 32'd2);
        chk("ign_dones", 32'(n_done), 32'd2);

        // reset in RUN cycle 10: everything clears at once, no later done
        issue(1'b0, 32'd50, 32'd5);
        repeat (10) @(negedge clock);
        #2 reset = 1'b0;
        #1 all_zero("rst_run");
        @(negedge clock);
        reset = 1'b1;
        zero_clr();
        repeat (45) @(negedge clock);
        chk("rst_dones", 32'(n_done), 32'd0);
        chk("rst_hi", hi_out, 32'd0);

`ifdef HILO_MTHILO_EN
        // mthi in IDLE; then mthi alongside start loses to start
        mt_en = 1'b1; mt_sel = 1'b1; mt_data = 32'hDEAD_BEEF;
        @(negedge clock);
        mt_en = 1'b0;
        chk("mthi", hi_out, 32'hDEAD_BEEF);
        chk("mthi_done", 32'(done), 32'd0);
        mt_en = 1'b1; mt_data = 32'h1234_5678;
        issue(1'b0, 32'd9, 32'd3);
        mt_en = 1'b0;
        chk("mt_start_hi", hi_out, 32'hDEAD_BEEF);
        wait_done("mt", n);
        chk("mt_res_hi", hi_out, 32'd1);
        @(negedge clock);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/hilo_sequencer.md
HILO_SEQUENCER -- requirements
Module: hilo_sequencer

Interface
REQ-001 Parameter DIV_LAT, default 33: clock cycles from unit_go to valid divider result (1..63).
REQ-002 Parameter MULT_LAT, default 33: clock cycles from unit_go to valid multiplier result (1..63).
REQ-003 clock  in  1  sole clock; all state on rising edge.
REQ-004 reset  in  1  asynchronous, active-low reset.
REQ-005 start  in  1  control unit requests mult/div; sampled only in IDLE.
REQ-006 op  in  1  0 = div, 1 = mult; sampled with start.
REQ-007 A, B  in  32 each  operands; sampled with start.
REQ-008 op_a, op_b  out  32 each  latched operands driven to divider and multiplier.
REQ-009 unit_go  out  1  one-cycle pulse to the selected unit when an operation is accepted.
REQ-010 div_hi, div_lo  in  32 each  divider remainder/quotient.
REQ-011 mult_hi, mult_lo  in  32 each  multiplier product high/low.
REQ-012 hi_out, lo_out  out  32 each  architectural HI/LO registers.
REQ-013 busy  out  1  high in RUN; control unit stalls mfhi/mflo/mult/div while set.
REQ-014 done  out  1  one-cycle pulse when HI/LO are updated or the operation terminates.
REQ-015 div0  out  1  one-cycle pulse, coincident with done, on divide by zero.
REQ-016 mt_en, mt_sel, mt_data  in  1/1/32  mthi (mt_sel=1) / mtlo (mt_sel=0) write port; present only with HILO_MTHILO_EN.

Function
REQ-017 States: IDLE, RUN, FIN; encoded in 2 bits; unused encoding returns to IDLE next cycle.
REQ-018 IDLE + start + (op=1 or B!=0): latch op, A->op_a, B->op_b, load 6-bit counter with MULT_LAT or DIV_LAT, assert unit_go for that cycle, go to RUN.
REQ-019 IDLE + start + op=0 + B==0: no unit_go, HI/LO unchanged; go to FIN with div0 flagged.
REQ-020 RUN: counter decrements by 1 per cycle; busy=1; op_a/op_b held constant; start ignored.
REQ-021 RUN with counter==1: on that edge HI<=selected unit's hi, LO<=selected unit's lo; go to FIN.
REQ-022 FIN: done=1 for exactly one cycle (div0=1 too if flagged); busy=0; clear flag; go to IDLE.
REQ-023 start asserted in FIN is ignored; earliest acceptance is the following IDLE cycle.
REQ-024 Result latency: done asserts LAT+1 cycles after the accepting edge; HI/LO valid in the done cycle.
REQ-025 Divide-by-zero latency: done and div0 assert in the cycle after acceptance.
REQ-026 No arithmetic is performed here; HI/LO are copied bit-exact, with no sign or width changes.

Reset
REQ-027 reset low, at any time including mid-RUN: state=IDLE, counter=0, hi_out=lo_out=op_a=op_b=0, busy=done=div0=unit_go=0, immediately and asynchronously.
REQ-028 An operation interrupted by reset is abandoned; no HI/LO write occurs after release.
REQ-029 First start accepted on the first rising edge after reset deasserts.

Configuration
REQ-030 Macro HILO_MTHILO_EN defined: mt_en in IDLE writes mt_data to HI (mt_sel=1) or LO (mt_sel=0) on that edge, without done.
REQ-031 With HILO_MTHILO_EN: mt_en in RUN or FIN is ignored; start and mt_en in the same IDLE cycle: start wins, write discarded.
REQ-032 HILO_MTHILO_EN undefined: mt_en/mt_sel/mt_data ports are absent; HI/LO are written only by REQ-021.

Verification
REQ-033 div A=100, B=7, stub divider returns hi=2 lo=14 -> unit_go once, busy 33 cycles, done at cycle 34, hi_out=2, lo_out=14, div0=0.
REQ-034 div A=5, B=0 -> no unit_go, done and div0 pulse next cycle, HI/LO keep prior values.
REQ-035 mult A=0xFFFFFFFF, B=2, stub returns hi=1 lo=0xFFFFFFFE -> hi_out=1, lo_out=0xFFFFFFFE after MULT_LAT+1 cycles.
REQ-036 start pulsed during RUN, then again in FIN -> both ignored, a single done; start in the next IDLE cycle is accepted.
REQ-037 reset low at RUN cycle 10 -> all outputs 0 immediately; no done after release.
REQ-038 HILO_MTHILO_EN: mt_en=1, mt_sel=1, mt_data=0xDEADBEEF in IDLE -> hi_out=0xDEADBEEF next cycle; mt_en with start in the same cycle -> HI unchanged.
